sa2_operand_loader: RTL and testbench



---
 rtl/sa2_operand_loader.sv | 154 +++++++++++++++
 tb/tb_sa2_operand_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sa2_operand_loader.sv
// sa2_operand_loader: assembles a 4x4 input tile and a 3x3 filter from a
// valid/ready byte stream, then holds them stable while the 2x2 systolic
// array runs (active_sa2 high) until the array returns done_sa2.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   in_valid, in_data  byte stream in; in_ready out (high in LOAD_A/LOAD_B)
//   done_sa2           completion pulse from the array
//   active_sa2         start/hold level to the array (registered)
//   a11..a44, b11..b33 operand holding registers (row-major)
//   frame_cnt          completed frames, modulo 256
//   keep_filter        only with SA2_LOADER_FILTER_REUSE_EN: skip LOAD_B and
//                      reuse the previous filter once a frame has completed
module sa2_operand_loader #(
    parameter int DATA_W = 8,
    parameter int N_DATA = 16,
    parameter int N_FILT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              done_sa2,
`ifdef SA2_LOADER_FILTER_REUSE_EN
    input  logic              keep_filter,
`endif
    output logic              active_sa2,
    output logic [DATA_W-1:0] a11, a12, a13, a14,
    output logic [DATA_W-1:0] a21, a22, a23, a24,
    output logic [DATA_W-1:0] a31, a32, a33, a34,
    output logic [DATA_W-1:0] a41, a42, a43, a44,
    output logic [DATA_W-1:0] b11, b12, b13,
    output logic [DATA_W-1:0] b21, b22, b23,
    output logic [DATA_W-1:0] b31, b32, b33,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [3:0] A_LAST = 4'(N_DATA - 1);
    localparam logic [3:0] B_LAST = 4'(N_FILT - 1);

    state_t            state;
    logic [3:0]        idx;
    logic [DATA_W-1:0] a_q [N_DATA];
    logic [DATA_W-1:0] b_q [N_FILT];
    logic              accept;
    logic              skip_b;

`ifdef SA2_LOADER_FILTER_REUSE_EN
    // Separate flag: frame_cnt may wrap back to 0 after many frames.
    logic have_frame;
    assign skip_b = keep_filter && have_frame;
`else
    assign skip_b = 1'b0;
`endif

    assign in_ready = (state != RUN);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_A;
            idx        <= '0;
            active_sa2 <= 1'b0;
            frame_cnt  <= '0;
            for (int i = 0; i < N_DATA; i++) a_q[i] <= '0;
            for (int i = 0; i < N_FILT; i++) b_q[i] <= '0;
`ifdef SA2_LOADER_FILTER_REUSE_EN
            have_frame <= 1'b0;
`endif
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (accept) begin
                        a_q[idx] <= in_data;
                        if (idx == A_LAST) begin
                            idx <= '0;
                            if (skip_b) begin
                                state      <= RUN;
                                active_sa2 <= 1'b1;
                            end else begin
                                state <= LOAD_B;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        b_q[idx] <= in_data;
                        if (idx == B_LAST) begin
                            idx        <= '0;
                            state      <= RUN;
                            active_sa2 <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                RUN: begin
                    // Array idles on this same edge, so it sees
                    // active_sa2 low and does not restart.
                    if (done_sa2) begin
                        active_sa2 <= 1'b0;
                        frame_cnt  <= frame_cnt + 8'd1;
                        state      <= LOAD_A;
`ifdef SA2_LOADER_FILTER_REUSE_EN
                        have_frame <= 1'b1;
`endif
                    end
                end
                default: begin
                    state      <= LOAD_A;
                    idx        <= '0;
                    active_sa2 <= 1'b0;
                end
            endcase
        end
    end

    assign a11 = a_q[0];
    assign a12 = a_q[1];
    assign a13 = a_q[2];
    assign a14 = a_q[3];
    assign a21 = a_q[4];
    assign a22 = a_q[5];
    assign a23 = a_q[6];
    assign a24 = a_q[7];
    assign a31 = a_q[8];
    assign a32 = a_q[9];
    assign a33 = a_q[10];
    assign a34 = a_q[11];
    assign a41 = a_q[12];
    assign a42 = a_q[13];
    assign a43 = a_q[14];
    assign a44 = a_q[15];

    assign b11 = b_q[0];
    assign b12 = b_q[1];
    assign b13 = b_q[2];
    assign b21 = b_q[3];
    assign b22 = b_q[4];
    assign b23 = b_q[5];
    assign b31 = b_q[6];
    assign b32 = b_q[7];
    assign b33 = b_q[8];

endmodule

// File: tb/tb_sa2_operand_loader.sv
// tb_sa2_operand_loader: directed bench for sa2_operand_loader.
// Table-driven gap/done sequence plus hand-written frame and reset cases.
module tb_sa2_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       done_sa2;
    logic       active_sa2;
    logic [7:0] frame_cnt;
    logic [7:0] a_o [16];
    logic [7:0] b_o [9];
`ifdef SA2_LOADER_FILTER_REUSE_EN
    logic       keep_filter;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sa2_operand_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .done_sa2(done_sa2),
`ifdef SA2_LOADER_FILTER_REUSE_EN
        .keep_filter(keep_filter),
`endif
        .active_sa2(active_sa2),
        .a11(a_o[0]),  .a12(a_o[1]),  .a13(a_o[2]),  .a14(a_o[3]),
        .a21(a_o[4]),  .a22(a_o[5]),  .a23(a_o[6]),  .a24(a_o[7]),
        .a31(a_o[8]),  .a32(a_o[9]),  .a33(a_o[10]), .a34(a_o[11]),
        .a41(a_o[12]), .a42(a_o[13]), .a43(a_o[14]), .a44(a_o[15]),
        .b11(b_o[0]), .b12(b_o[1]), .b13(b_o[2]),
        .b21(b_o[3]), .b22(b_o[4]), .b23(b_o[5]),
        .b31(b_o[6]), .b32(b_o[7]), .b33(b_o[8]),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       done;
        logic       exp_rdy;
        logic       exp_act;
        logic [7:0] exp_frm;
    } vec_t;

    vec_t vt [64];
    int   n_vt;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_ops(input string tag, input int a0, input int b0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_a%0d", tag, i), int'(a_o[i]), a0 + i);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_b%0d", tag, i), int'(b_o[i]), b0 + i);
    endtask

    initial begin
        int acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        done_sa2 = 1'b0;
`ifdef SA2_LOADER_FILTER_REUSE_EN
        keep_filter = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_ready", in_ready, 1);
        chk("rst_active", active_sa2, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_a11", a_o[0], 0);
        chk("rst_b33", b_o[8], 0);

        // Frame 1: continuous bytes 1..25
        for (int k = 0; k < 25; k++) begin
            chk($sformatf("f1_rdy%0d", k), in_ready, 1);
            chk($sformatf("f1_act%0d", k), active_sa2, 0);
            send(8'(k + 1));
        end
        chk("f1_active_after_b33", active_sa2, 1);
        chk("f1_ready_run", in_ready, 0);
        chk("f1_a11", a_o[0], 1);
        chk("f1_a44", a_o[15], 16);
        chk("f1_b11", b_o[0], 17);
        chk("f1_b33", b_o[8], 25);

        // Bytes offered during RUN must be ignored
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("run_act%0d", c), active_sa2, 1);
            chk($sformatf("run_rdy%0d", c), in_ready, 0);
        end
        done_sa2 = 1'b1;
        step();
        done_sa2 = 1'b0;
        in_valid = 1'b0;
        chk("done_active", active_sa2, 0);
        chk("done_ready", in_ready, 1);
        chk("done_frame", frame_cnt, 1);
        chk_ops("f1_hold", 1, 17);

        // Frame 2: toggling valid, held junk in gaps, done at idx 7
        n_vt = 0;
        acc  = 0;
        for (int k = 0; k < 25; k++) begin
            acc++;
            vt[n_vt] = '{1'b1, 8'(101 + k), 1'b0,
                         acc < 25, acc == 25, 8'd1};
            n_vt++;
            if (k < 24) begin
                vt[n_vt] = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 8'd1};
                n_vt++;
            end
            if (acc == 7) begin
                vt[n_vt] = '{1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 8'd1};
                n_vt++;
            end
        end
        for (int r = 0; r < n_vt; r++) begin
            in_valid = vt[r].v;
            in_data  = vt[r].d;
            done_sa2 = vt[r].done;
            step();
            chk($sformatf("vt%0d_rdy", r), in_ready, vt[r].exp_rdy);
            chk($sformatf("vt%0d_act", r), active_sa2, vt[r].exp_act);
            chk($sformatf("vt%0d_frm", r), frame_cnt, vt[r].exp_frm);
        end
        in_valid = 1'b0;
        done_sa2 = 1'b0;
        chk("f2_a23_7th", a_o[6], 107);
        chk_ops("f2", 101, 117);
        step();
        done_sa2 = 1'b1;
        step();
        done_sa2 = 1'b0;
        chk("f2_frame", frame_cnt, 2);
        chk("f2_ready", in_ready, 1);

        // Async reset after 20 accepted bytes
        for (int k = 0; k < 20; k++) send(8'(201 + k));
        chk("pre_rst_b13", b_o[2], 219);
        #2 rst = 1'b1;
        #1;
        chk("async_a11", a_o[0], 0);
        chk("async_b11", b_o[0], 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_frame", frame_cnt, 0);
        chk("mid_rst_active", active_sa2, 0);
        chk("mid_rst_a44", a_o[15], 0);
        send(8'd77);
        chk("post_rst_a11", a_o[0], 77);
        chk("post_rst_a12", a_o[1], 0);

`ifdef SA2_LOADER_FILTER_REUSE_EN
        // keep_filter before any completed frame: LOAD_B still taken
        rst = 1'b1;
        step();
        rst = 1'b0;
        keep_filter = 1'b1;
        for (int k = 0; k < 16; k++) send(8'(11 + k));
        chk("kf0_active", active_sa2, 0);
        chk("kf0_ready", in_ready, 1);
        for (int k = 0; k < 9; k++) send(8'(31 + k));
        chk("kf0_run", active_sa2, 1);
        done_sa2 = 1'b1;
        step();
        done_sa2 = 1'b0;
        chk("kf0_frame", frame_cnt, 1);
        for (int k = 0; k < 16; k++) send(8'(41 + k));
        chk("kf1_active", active_sa2, 1);
        chk("kf1_ready", in_ready, 0);
        chk_ops("kf1", 41, 31);
        done_sa2 = 1'b1;
        step();
        done_sa2 = 1'b0;
        chk("kf1_frame", frame_cnt, 2);
        keep_filter = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
